// File: rtl/serial_tx4.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Define PARITY_EN to compile in the parity bit; the default build sends WIDTH+2 bits per frame.
module serial_tx4 #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic             ONE_CLK  = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             tx_reg;
  logic             done_reg;
`ifdef PARITY_EN
  logic             parity_reg;
`endif

  logic             bit_end;
  logic [WIDTH-1:0] shift_next;

  assign bit_end    = (div_reg == DIV_LAST);
  assign shift_next = shift_reg >> 1;

  // tx is loaded with the value of the bit that starts on the same edge, so it is glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      div_reg    <= '0;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
`ifdef PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg  <= in_data;
            cnt_reg    <= '0;
            div_reg    <= '0;
            tx_reg     <= 1'b0;
            state_reg  <= START;
`ifdef PARITY_EN
            parity_reg <= ^in_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            div_reg   <= '0;
            tx_reg    <= shift_reg[0];
            state_reg <= DATA;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_reg   <= '0;
            shift_reg <= shift_next;
            if (cnt_reg == CNT_LAST) begin
`ifdef PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              done_reg  <= ONE_CLK;
              state_reg <= STOP;
`endif
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
              tx_reg  <= shift_next[0];
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) begin
            div_reg   <= '0;
            tx_reg    <= 1'b1;
            done_reg  <= ONE_CLK;
            state_reg <= STOP;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            div_reg   <= '0;
            tx_reg    <= 1'b1;
            state_reg <= IDLE;
          end else begin
            div_reg  <= div_reg + 1'b1;
            // done must be visible during the final stop cycle
            done_reg <= (div_reg == DIV_PRE);
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign done     = done_reg;
  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);

endmodule
